// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit.
package cu_pkg;

    // RV32I major opcodes recognised by the control unit.
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_WB,
        ST_INTR,
        ST_TRAP
    } cu_state_t;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_BUS     = 2'b10;

    // Width of an index into n items, never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder for interrupt requests.
module intr_prio_enc #(
    parameter int NUM_INTR = 4,
    parameter int CW       = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1
) (
    input  logic [NUM_INTR-1:0] req,
    output logic                valid,
    output logic [CW-1:0]       idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_INTR - 1; i >= 0; i--) begin
            if (req[i]) idx = CW'(i);
        end
    end

endmodule

// File: rtl/cu_fsm_mc.sv
// Multicycle RV32I control unit: fetch/execute/writeback sequencing with
// memory wait states, prioritised interrupts, CSR/MRET decode and traps.
module cu_fsm_mc
    import cu_pkg::*;
#(
    parameter int NUM_INTR = 4,
    parameter int WAIT_MAX = 15,
    parameter int CW       = cw_of(NUM_INTR)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_INTR-1:0] INTR,
    input  logic                INTR_EN,
    input  logic [6:0]          CU_OPCODE,
    input  logic [2:0]          FUNC3,
    input  logic                MEM_READY,
    output logic                PC_WRITE,
    output logic                REG_WRITE,
    output logic                MEM_WRITE,
    output logic                MEM_READ1,
    output logic                MEM_READ2,
    output logic                CSR_WRITE,
    output logic                MRET_EXEC,
    output logic                INT_TAKEN,
    output logic [CW-1:0]       INT_CAUSE,
    output logic                TRAP_TAKEN,
    output logic [1:0]          TRAP_CAUSE
);

    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

    cu_state_t     state, state_nx;
    logic [WW-1:0] wcnt, wcnt_nx, wcnt_inc;
    logic [1:0]    tcause_nx;
    logic          ins_end, int_ld;
    logic [NUM_INTR-1:0] pend;
    logic          pend_vld;
    logic [CW-1:0] pend_idx;
    opcode_t       opc;

    assign opc      = opcode_t'(CU_OPCODE);
    assign pend     = INTR & {NUM_INTR{INTR_EN}};
    // The counter is cleared on every trap entry, so it never exceeds WMAX.
    assign wcnt_inc = (wcnt == WMAX) ? wcnt : wcnt + WW'(1);

    intr_prio_enc #(.NUM_INTR(NUM_INTR), .CW(CW)) u_prio (
        .req   (pend),
        .valid (pend_vld),
        .idx   (pend_idx)
    );

    // Next state, wait counter, trap cause and datapath strobes.
    always_comb begin
        state_nx   = state;
        wcnt_nx    = wcnt;
        tcause_nx  = TRAP_CAUSE;
        ins_end    = 1'b0;
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        MEM_WRITE  = 1'b0;
        MEM_READ1  = 1'b0;
        MEM_READ2  = 1'b0;
        CSR_WRITE  = 1'b0;
        MRET_EXEC  = 1'b0;
        INT_TAKEN  = 1'b0;
        TRAP_TAKEN = 1'b0;
        case (state)
            ST_FETCH: begin
                MEM_READ1 = 1'b1;
                if (MEM_READY) begin
                    state_nx = ST_EXEC;
                    wcnt_nx  = '0;
                end else if (wcnt_inc == WMAX) begin
                    state_nx  = ST_TRAP;
                    tcause_nx = TC_BUS;
                    wcnt_nx   = '0;
                end else begin
                    wcnt_nx = wcnt_inc;
                end
            end
            ST_EXEC: begin
                case (opc)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: begin
                        PC_WRITE  = 1'b1;
                        REG_WRITE = 1'b1;
                        ins_end   = 1'b1;
                    end
                    OPC_BRANCH: begin
                        PC_WRITE = 1'b1;
                        ins_end  = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        if (FUNC3 == F3_CSRRW || FUNC3 == F3_CSRRS || FUNC3 == F3_CSRRC) begin
                            PC_WRITE  = 1'b1;
                            REG_WRITE = 1'b1;
                            CSR_WRITE = 1'b1;
                            ins_end   = 1'b1;
                        end else if (FUNC3 == F3_MRET) begin
                            PC_WRITE  = 1'b1;
                            MRET_EXEC = 1'b1;
                            ins_end   = 1'b1;
                        end else begin
                            state_nx  = ST_TRAP;
                            tcause_nx = TC_ILLEGAL;
                        end
                    end
                    OPC_LOAD: begin
                        MEM_READ2 = 1'b1;
                        state_nx  = MEM_READY ? ST_WB : ST_MEM_WAIT;
                    end
                    OPC_STORE: begin
                        MEM_WRITE = 1'b1;
                        if (MEM_READY) begin
                            PC_WRITE = 1'b1;
                            ins_end  = 1'b1;
                        end else begin
                            state_nx = ST_MEM_WAIT;
                        end
                    end
                    default: begin
                        state_nx  = ST_TRAP;
                        tcause_nx = TC_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_WAIT: begin
                // The instruction register holds the opcode across wait states.
                MEM_READ2 = (opc == OPC_LOAD);
                MEM_WRITE = (opc != OPC_LOAD);
                if (MEM_READY) begin
                    wcnt_nx = '0;
                    if (opc == OPC_LOAD) begin
                        state_nx = ST_WB;
                    end else begin
                        PC_WRITE = 1'b1;
                        ins_end  = 1'b1;
                    end
                end else if (wcnt_inc == WMAX) begin
                    state_nx  = ST_TRAP;
                    tcause_nx = TC_BUS;
                    wcnt_nx   = '0;
                end else begin
                    wcnt_nx = wcnt_inc;
                end
            end
            ST_WB: begin
                REG_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
                ins_end   = 1'b1;
            end
            ST_INTR: begin
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
                state_nx  = ST_FETCH;
            end
            ST_TRAP: begin
                TRAP_TAKEN = 1'b1;
                PC_WRITE   = 1'b1;
                state_nx   = ST_FETCH;
            end
            default: state_nx = ST_FETCH;
        endcase
        // A completing instruction either enters the interrupt handler or fetches.
        if (ins_end) state_nx = pend_vld ? ST_INTR : ST_FETCH;
        if (!RST_N) begin
            PC_WRITE   = 1'b0;
            REG_WRITE  = 1'b0;
            MEM_WRITE  = 1'b0;
            MEM_READ1  = 1'b0;
            MEM_READ2  = 1'b0;
            CSR_WRITE  = 1'b0;
            MRET_EXEC  = 1'b0;
            INT_TAKEN  = 1'b0;
            TRAP_TAKEN = 1'b0;
        end
    end

    assign int_ld = ins_end && pend_vld;

    // State, wait counter and cause registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_FETCH;
            wcnt       <= '0;
            INT_CAUSE  <= '0;
            TRAP_CAUSE <= '0;
        end else begin
            state      <= state_nx;
            wcnt       <= wcnt_nx;
            TRAP_CAUSE <= tcause_nx;
            if (int_ld) INT_CAUSE <= pend_idx;
        end
    end

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Self-checking bench for cu_fsm_mc: decode table, directed corner cases and
// randomized instruction streams against a procedural per-instruction model.
module tb_cu_fsm_mc;

    localparam int NI = 4;
    localparam int WM = 15;
    localparam int CW = 2;

    // ISA opcodes, written out independently of the design package.
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011,
                           SYSTEM = 7'b1110011, BAD = 7'b1111111;

    // Strobe vector bits: {PC,RW,MW,R1,R2,CSR,MRET,INT,TRAP}.
    localparam logic [8:0] S_PC = 9'h100, S_RW = 9'h080, S_MW = 9'h040, S_R1 = 9'h020,
                           S_R2 = 9'h010, S_CSR = 9'h008, S_MRET = 9'h004,
                           S_INT = 9'h002, S_TRAP = 9'h001;

    logic CLK = 1'b0, RST_N = 1'b0;
    logic [NI-1:0] INTR = '0;
    logic INTR_EN = 1'b0, MEM_READY = 1'b0;
    logic [6:0] CU_OPCODE = '0;
    logic [2:0] FUNC3 = '0;
    logic PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WRITE, MRET_EXEC;
    logic INT_TAKEN, TRAP_TAKEN;
    logic [CW-1:0] INT_CAUSE;
    logic [1:0] TRAP_CAUSE;

    cu_fsm_mc #(.NUM_INTR(NI), .WAIT_MAX(WM)) dut (
        .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .INTR_EN(INTR_EN),
        .CU_OPCODE(CU_OPCODE), .FUNC3(FUNC3), .MEM_READY(MEM_READY),
        .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE), .MEM_WRITE(MEM_WRITE),
        .MEM_READ1(MEM_READ1), .MEM_READ2(MEM_READ2), .CSR_WRITE(CSR_WRITE),
        .MRET_EXEC(MRET_EXEC), .INT_TAKEN(INT_TAKEN), .INT_CAUSE(INT_CAUSE),
        .TRAP_TAKEN(TRAP_TAKEN), .TRAP_CAUSE(TRAP_CAUSE)
    );

    always #5 CLK = ~CLK;

    wire [8:0] strb = {PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2,
                       CSR_WRITE, MRET_EXEC, INT_TAKEN, TRAP_TAKEN};

    int nvec = 0, nmiss = 0;
    int rdy_mode = 0;          // 0 always ready, 1 mostly ready, 2 never, 3 rarely
    bit intr_rand = 1'b0;
    bit q_rdy[$];              // forced MEM_READY values, consumed first
    logic [CW-1:0] m_icause;
    logic [1:0]    m_tcause;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [8:0] e_exec;    // strobes in the execute cycle
        logic [8:0] e_next;    // strobes in the following cycle, 0 if it is a fetch
        logic [1:0] tc;        // TRAP_CAUSE once the row is done
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic get_rdy(output bit r);
        if (q_rdy.size() > 0) r = q_rdy.pop_front();
        else case (rdy_mode)
            0: r = 1'b1;
            1: r = ($urandom_range(0, 9) < 7);
            2: r = 1'b0;
            default: r = ($urandom_range(0, 3) == 0);
        endcase
    endtask

    // One clock: drive inputs, check strobes and causes, advance past the edge.
    task automatic cyc(input bit rdy, input logic [8:0] exp, input string nm,
                       output logic [NI-1:0] p);
        MEM_READY = rdy;
        if (intr_rand) begin
            INTR    = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
            INTR_EN = 1'($urandom_range(0, 1));
        end
        p = INTR & {NI{INTR_EN}};
        #2;
        chk(nm, 16'(strb), 16'(exp));
        chk({nm, "_icause"}, 16'(INT_CAUSE), 16'(m_icause));
        chk({nm, "_tcause"}, 16'(TRAP_CAUSE), 16'(m_tcause));
        @(posedge CLK); #1;
    endtask

    task automatic trap_entry(input logic [1:0] c);
        logic [NI-1:0] p;
        bit r;
        m_tcause = c;
        get_rdy(r);
        cyc(r, S_PC | S_TRAP, "trap", p);
    endtask

    // Cycle in which an instruction completes; a pending, enabled request
    // then costs one interrupt-entry cycle with the lowest pending index.
    task automatic end_cycle(input bit rdy, input logic [8:0] exp, input string nm);
        logic [NI-1:0] p;
        bit r;
        cyc(rdy, exp, nm, p);
        if (p != '0) begin
            for (int i = NI - 1; i >= 0; i--) if (p[i]) m_icause = CW'(i);
            get_rdy(r);
            cyc(r, S_PC | S_INT, "intr", p);
        end
    endtask

    task automatic mem_wait(input bit ld);
        logic [NI-1:0] p;
        bit r, got;
        got = 1'b0;
        for (int w = 1; w <= WM && !got; w++) begin
            get_rdy(r);
            if (r) begin
                got = 1'b1;
                if (ld) cyc(1'b1, S_R2, "wait_ld_done", p);
                else    end_cycle(1'b1, S_MW | S_PC, "wait_st_done");
            end else begin
                cyc(1'b0, ld ? S_R2 : S_MW, "wait", p);
            end
        end
        if (!got) trap_entry(2'b10);
        else if (ld) begin
            get_rdy(r);
            end_cycle(r, S_PC | S_RW, "wb");
        end
    endtask

    // Whole-instruction model: fetch with bounded wait, then execute by class.
    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3);
        logic [NI-1:0] p;
        bit r, got;
        CU_OPCODE = opc;
        FUNC3     = f3;
        got = 1'b0;
        for (int n = 1; n <= WM && !got; n++) begin
            get_rdy(r);
            cyc(r, S_R1, "fetch", p);
            got = r;
        end
        if (!got) begin
            trap_entry(2'b10);
            return;
        end
        get_rdy(r);
        if (opc == LUI || opc == AUIPC || opc == JAL || opc == JALR || opc == OP || opc == OPIMM)
            end_cycle(r, S_PC | S_RW, "exec_alu");
        else if (opc == BRANCH)
            end_cycle(r, S_PC, "exec_br");
        else if (opc == SYSTEM && f3 >= 3'd1 && f3 <= 3'd3)
            end_cycle(r, S_PC | S_RW | S_CSR, "exec_csr");
        else if (opc == SYSTEM && f3 == 3'd0)
            end_cycle(r, S_PC | S_MRET, "exec_mret");
        else if (opc == LOAD) begin
            cyc(r, S_R2, "exec_ld", p);
            if (r) begin
                get_rdy(r);
                end_cycle(r, S_PC | S_RW, "wb");
            end else mem_wait(1'b1);
        end else if (opc == STORE) begin
            if (r) end_cycle(1'b1, S_MW | S_PC, "exec_st");
            else begin
                cyc(1'b0, S_MW, "exec_st", p);
                mem_wait(1'b0);
            end
        end else begin
            cyc(r, 9'h000, "exec_ill", p);
            trap_entry(2'b01);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NI-1:0] p;
        logic [6:0] ops[11];
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM, BAD};

        tbl[0]  = '{LUI,    3'd0, S_PC | S_RW,         9'h000,       2'b00};
        tbl[1]  = '{AUIPC,  3'd5, S_PC | S_RW,         9'h000,       2'b00};
        tbl[2]  = '{JAL,    3'd0, S_PC | S_RW,         9'h000,       2'b00};
        tbl[3]  = '{JALR,   3'd0, S_PC | S_RW,         9'h000,       2'b00};
        tbl[4]  = '{OP,     3'd7, S_PC | S_RW,         9'h000,       2'b00};
        tbl[5]  = '{OPIMM,  3'd2, S_PC | S_RW,         9'h000,       2'b00};
        tbl[6]  = '{BRANCH, 3'd1, S_PC,                9'h000,       2'b00};
        tbl[7]  = '{SYSTEM, 3'd1, S_PC | S_RW | S_CSR, 9'h000,       2'b00};
        tbl[8]  = '{SYSTEM, 3'd2, S_PC | S_RW | S_CSR, 9'h000,       2'b00};
        tbl[9]  = '{SYSTEM, 3'd3, S_PC | S_RW | S_CSR, 9'h000,       2'b00};
        tbl[10] = '{SYSTEM, 3'd0, S_PC | S_MRET,       9'h000,       2'b00};
        tbl[11] = '{LOAD,   3'd2, S_R2,                S_PC | S_RW,  2'b00};
        tbl[12] = '{STORE,  3'd2, S_MW | S_PC,         9'h000,       2'b00};
        tbl[13] = '{SYSTEM, 3'd5, 9'h000,              S_PC | S_TRAP, 2'b01};
        tbl[14] = '{BAD,    3'd0, 9'h000,              S_PC | S_TRAP, 2'b01};

        // Reset: strobes forced low, causes cleared.
        RST_N = 1'b0;
        @(posedge CLK); #1;
        m_icause = '0;
        m_tcause = '0;
        cyc(1'b1, 9'h000, "reset", p);
        RST_N = 1'b1;

        // Decode table with MEM_READY tied high and no interrupts.
        foreach (tbl[i]) begin
            CU_OPCODE = tbl[i].opc;
            FUNC3     = tbl[i].f3;
            cyc(1'b1, S_R1, $sformatf("tbl%0d_fetch", i), p);
            cyc(1'b1, tbl[i].e_exec, $sformatf("tbl%0d_exec", i), p);
            m_tcause = tbl[i].tc;
            if (tbl[i].e_next != 9'h000)
                cyc(1'b1, tbl[i].e_next, $sformatf("tbl%0d_next", i), p);
        end

        // Legacy timing: OP, LOAD, STORE, BRANCH back to back.
        rdy_mode = 0;
        run_instr(OP, 3'd0);
        run_instr(LOAD, 3'd2);
        run_instr(STORE, 3'd2);
        run_instr(BRANCH, 3'd0);

        // LOAD with three not-ready cycles: MEM_READ2 for four cycles then WB.
        q_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_instr(LOAD, 3'd2);

        // Fetch never ready: fifteen fetch cycles then a bus trap.
        rdy_mode = 2;
        run_instr(OP, 3'd0);
        rdy_mode = 0;
        run_instr(OP, 3'd0);

        // Interrupt at instruction end, then with the global enable off.
        INTR = 4'b1010; INTR_EN = 1'b1;
        run_instr(OPIMM, 3'd0);
        INTR_EN = 1'b0;
        run_instr(OPIMM, 3'd0);

        // Illegal instruction with a pending interrupt: trap first, interrupt later.
        INTR = 4'b0100; INTR_EN = 1'b1;
        run_instr(BAD, 3'd0);
        run_instr(OP, 3'd0);
        INTR = 4'b1010;
        run_instr(SYSTEM, 3'd0);
        INTR = '0; INTR_EN = 1'b0;

        // Reset during a STORE wait state abandons the access.
        CU_OPCODE = STORE; FUNC3 = 3'd2;
        cyc(1'b1, S_R1, "rst_fetch", p);
        cyc(1'b0, S_MW, "rst_exec", p);
        cyc(1'b0, S_MW, "rst_wait", p);
        RST_N = 1'b0;
        cyc(1'b1, 9'h000, "rst_mid_store", p);
        RST_N = 1'b1;
        m_icause = '0;
        m_tcause = '0;
        CU_OPCODE = OP; FUNC3 = 3'd0;
        cyc(1'b1, S_R1, "post_rst_fetch", p);
        end_cycle(1'b1, S_PC | S_RW, "post_rst_exec");

        // Random streams: mostly-ready memory, then a slow bus to hit timeouts.
        intr_rand = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            rdy_mode = (phase == 0) ? 1 : 3;
            for (int k = 0; k < 200; k++) begin
                logic [6:0] o;
                o = ops[$urandom_range(0, 10)];
                if (o == BAD) o = 7'($urandom);
                run_instr(o, 3'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule

// File: doc/cu_fsm_mc.md
Name: cu_fsm_mc

Overview:
Next-generation multicycle control-unit FSM for the RV32I core. Sequences fetch/execute/writeback and adds:
- a memory ready handshake with bounded wait states;
- NUM_INTR prioritised, globally enabled interrupt sources with a registered cause;
- CSRRW/CSRRS/CSRRC and MRET decode;
- illegal-instruction and bus-timeout traps.

It drives the same datapath strobes as the current control unit.

Parameters:
NUM_INTR, 4, number of interrupt request lines; index 0 is highest priority.
WAIT_MAX, 15, maximum consecutive cycles a memory access may wait for MEM_READY before a bus-fault trap; must be ≥1.
CW, $clog2(NUM_INTR) (min 1), width of INT_CAUSE.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST_N  in  1  synchronous active-low reset.
INTR  in  NUM_INTR  level interrupt requests.
INTR_EN  in  1  global interrupt enable (mstatus.MIE from CSR file).
CU_OPCODE  in  7  instruction opcode.
FUNC3  in  3  instruction funct3.
MEM_READY  in  1  memory access complete this cycle.
PC_WRITE  out  1  PC load strobe.
REG_WRITE  out  1  register-file write strobe.
MEM_WRITE  out  1  data-memory write request.
MEM_READ1  out  1  instruction-fetch read request.
MEM_READ2  out  1  data-memory read request.
CSR_WRITE  out  1  CSR write strobe.
MRET_EXEC  out  1  MRET executing; CSR file restores MIE, PC mux selects MEPC.
INT_TAKEN  out  1  interrupt entry strobe.
INT_CAUSE  out  CW  index of the interrupt being taken; registered.
TRAP_TAKEN  out  1  synchronous trap entry strobe.
TRAP_CAUSE  out  2  01 illegal instruction, 10 bus timeout; registered.

Behaviour:
- States: FETCH, EXEC, MEM_WAIT, WB, INTR, TRAP.
- Strobes are combinational from state/inputs. INT_CAUSE, TRAP_CAUSE, state and the wait counter are registered.
- Reset (RST_N=0 at edge): state←FETCH, wait counter←0, INT_CAUSE←0, TRAP_CAUSE←0. While RST_N=0, all strobes are forced to 0 combinationally. Reset mid-access abandons the access; there is no completion strobe.
- FETCH:
  - MEM_READ1=1.
  - MEM_READY=1 → EXEC, counter←0.
  - Else counter+1; counter==WAIT_MAX → TRAP with cause 10.
- EXEC, by opcode:
  - LUI, AUIPC, JAL, JALR, OP, OP_IMM: PC_WRITE=1, REG_WRITE=1.
  - BRANCH: PC_WRITE=1.
  - SYSTEM, FUNC3 001/010/011: PC_WRITE=1, REG_WRITE=1, CSR_WRITE=1.
  - SYSTEM, FUNC3 000: PC_WRITE=1, MRET_EXEC=1.
  - LOAD: MEM_READ2=1. MEM_READY=1 → WB; else → MEM_WAIT.
  - STORE: MEM_WRITE=1; PC_WRITE=MEM_READY. Not ready → MEM_WAIT.
  - Any other opcode, or SYSTEM with other FUNC3: no strobes, → TRAP with cause 01.
- MEM_WAIT:
  - Holds MEM_READ2 or MEM_WRITE per opcode.
  - On MEM_READY: LOAD → WB; STORE asserts PC_WRITE this cycle and ends the instruction.
  - Counter increments each non-ready cycle; reaching WAIT_MAX → TRAP with cause 10, and no PC_WRITE for that instruction.
- WB: REG_WRITE=1, PC_WRITE=1; ends the instruction.
- Instruction end occurs at the EXEC/MEM_WAIT/WB cycle that asserts PC_WRITE for a completing instruction.
  - pend = INTR & {NUM_INTR{INTR_EN}}.
  - pend≠0 → INTR state, INT_CAUSE←index of lowest set bit.
  - Else → FETCH.
- MRET: the interrupt check still applies in the same cycle, using the current INTR_EN.
- INTR: INT_TAKEN=1, PC_WRITE=1, one cycle, → FETCH. INT_CAUSE holds until the next interrupt entry.
- TRAP: TRAP_TAKEN=1, PC_WRITE=1, one cycle, → FETCH.
  - Traps take precedence over pending interrupts.
  - A trapping instruction never triggers an interrupt check.
- Timing with MEM_READY tied to 1 (legacy-identical): 2 cycles per non-load instruction, 3 per load, +1 cycle per interrupt or trap entry.
- The counter saturates at WAIT_MAX and is cleared on every FETCH→EXEC and every MEM_WAIT exit.

Decomposition:
- Package cu_pkg holds:
  - opcode_t enum (LUI … SYSTEM);
  - cu_state_t enum;
  - FUNC3 constants (F3_MRET=000, F3_CSRRW=001, F3_CSRRS=010, F3_CSRRC=011);
  - trap cause constants (TC_ILLEGAL=2'b01, TC_BUS=2'b10).
- One sub-module, intr_prio_enc #(NUM_INTR): combinational lowest-index-first encoder with outputs valid and idx[CW-1:0].

Test Plan:
- MEM_READY=1; sequence OP, LOAD, STORE, BRANCH → per-instruction cycles 2, 3, 2, 2, with strobes per the EXEC/WB rules (LOAD shows MEM_READ2 then REG_WRITE+PC_WRITE).
- LOAD with MEM_READY low for 3 cycles → MEM_READ2 held 4 cycles, then WB; REG_WRITE asserted exactly once.
- Fetch with MEM_READY stuck 0, WAIT_MAX=15 → MEM_READ1 high 15 cycles, then TRAP_TAKEN=1 and PC_WRITE=1 for one cycle; TRAP_CAUSE=10.
- INTR=4'b1010, INTR_EN=1 during an OP_IMM EXEC → next cycle INT_TAKEN=1, INT_CAUSE=1. Same with INTR_EN=0 → FETCH, no INT_TAKEN.
- CU_OPCODE=7'b1111111 → no REG_WRITE/PC_WRITE in EXEC, then TRAP_TAKEN with cause 01; an interrupt pending at the same time is not taken until after the next instruction.
- RST_N=0 asserted during MEM_WAIT of a STORE → all strobes 0 that cycle; after release MEM_READ1=1 in FETCH; INT_CAUSE=0, TRAP_CAUSE=0.
